// File: rtl/seg7_pkg.sv
// ============================================================================
// Module      : seg7_pkg
// Description : Segment type, bit order and digit patterns for active-low
//               common-anode 7-segment displays.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam int SEG_A_BIT = 6;
    localparam int SEG_B_BIT = 5;
    localparam int SEG_C_BIT = 4;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 2;
    localparam int SEG_F_BIT = 1;
    localparam int SEG_G_BIT = 0;

    localparam seg_t SEG_0     = 7'b0000001;
    localparam seg_t SEG_1     = 7'b1001111;
    localparam seg_t SEG_2     = 7'b0010010;
    localparam seg_t SEG_3     = 7'b0000110;
    localparam seg_t SEG_4     = 7'b1001100;
    localparam seg_t SEG_5     = 7'b0100100;
    localparam seg_t SEG_6     = 7'b0100000;
    localparam seg_t SEG_7     = 7'b0001111;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0000100;
    localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

`default_nettype wire

// File: rtl/bcd_seg_decode.sv
// ============================================================================
// Module      : bcd_seg_decode
// Description : Combinational BCD to active-low 7-segment decoder; codes
//               10..15 produce a blank digit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bcd_seg_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output seg_t       seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
// Module      : seg7_scan_ctrl
// Description : Multiplexed scan controller for a common-anode multi-digit
//               7-segment display with blanking, leading-zero suppression
//               and a frame-synchronous load handshake.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] bcd_i,
    input  logic                    lzs_en_i,
    output logic                    ready_o,
    output seg_t                    seg_o,
    output logic [NUM_DIGITS-1:0]   an_o
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic [IDX_W-1:0]        idx_q,     idx_d;
    logic [4*NUM_DIGITS-1:0] disp_q,    disp_d;
    logic [4*NUM_DIGITS-1:0] shadow_q,  shadow_d;
    logic                    pending_q, pending_d;
    logic                    ready_q,   ready_d;
    seg_t                    seg_q,     seg_d;
    logic [NUM_DIGITS-1:0]   an_q,      an_d;

    logic [3:0]              w_nib [NUM_DIGITS];
    logic [3:0]              w_cur_nib;
    logic [NUM_DIGITS-1:0]   w_upper_zero;
    logic [NUM_DIGITS-1:0]   w_an_sel;
    logic                    w_slot_end;
    logic                    w_fe;
    logic                    w_blank;
    logic                    w_supp;
    logic                    v_zero;
    seg_t                    w_dec_seg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign w_nib[gi] = disp_q[4*gi +: 4];
        end
    endgenerate

    assign w_cur_nib = w_nib[idx_q];

    bcd_seg_decode u_dec (
        .bcd_i (w_cur_nib),
        .seg_o (w_dec_seg)
    );

    // w_upper_zero[i] is set when nibbles i..NUM_DIGITS-1 are all zero.
    always_comb begin
        w_upper_zero = '0;
        w_an_sel     = '0;
        v_zero       = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            v_zero          = v_zero & (w_nib[i] == 4'd0);
            w_upper_zero[i] = v_zero;
            w_an_sel[i]     = (idx_q == IDX_W'(i));
        end
    end

    assign w_slot_end = (cnt_q == CNT_W'(PRESCALE - 1));
    assign w_fe       = w_slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign w_blank    = (cnt_q < CNT_W'(BLANK_CYCLES));
    assign w_supp     = lzs_en_i && (idx_q != '0) && w_upper_zero[idx_q];

    always_comb begin
        cnt_d     = cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        disp_d    = disp_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        ready_d   = ready_q;
        seg_d     = w_dec_seg;
        an_d      = ~w_an_sel;

        if (w_slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        // A load on the frame-end cycle bypasses the shadow; otherwise it
        // waits there until the next frame end so a frame is never torn.
        if (ready_q && load_i) begin
            if (w_fe) begin
                disp_d = bcd_i;
            end else begin
                shadow_d  = bcd_i;
                pending_d = 1'b1;
                ready_d   = 1'b0;
            end
        end

        if (w_fe && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
            ready_d   = 1'b1;
        end

        if (w_blank) begin
            seg_d = SEG_BLANK;
            an_d  = '1;
        end else if (w_supp) begin
            seg_d = SEG_BLANK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            disp_q    <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            ready_q   <= 1'b1;
            seg_q     <= SEG_BLANK;
            an_q      <= '1;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign ready_o = ready_q;
    assign seg_o   = seg_q;
    assign an_o    = an_q;

endmodule

`default_nettype wire
